// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs LANES sync_fifo entries into one wide valid/ready word, with flush
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  output logic                        fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]            out_keep,
  output logic                        out_last
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] FULL = CW'(LANES);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                        state;
  state_t                        state_next;
  logic [DATA_WIDTH*LANES-1:0]   asm_data;
  logic [CW-1:0]                 asm_cnt;
  logic                          pend;
  logic                          slot_free;
  logic                          xfer;
  logic                          emit_fire;
  logic [CW-1:0]                 cnt_post;
  logic [CW:0]                   inflight;
  logic [DATA_WIDTH*LANES-1:0]   partial_data;
  logic [LANES-1:0]              partial_keep;

  // Handshake qualifiers and read issue; reads are capped so landed plus in-flight lanes never exceed LANES
  always_comb begin
    slot_free  = !out_valid || out_ready;
    xfer       = (asm_cnt == FULL) && slot_free;
    emit_fire  = (state == EMIT) && slot_free;
    cnt_post   = xfer ? '0 : asm_cnt;
    inflight   = {1'b0, cnt_post} + {{CW{1'b0}}, pend};
    fifo_rd_en = (state == FILL) && !flush && !fifo_empty && (inflight < (CW + 1)'(LANES));
  end

  // Partial word for a flush: lanes beyond asm_cnt are zeroed and masked off
  always_comb begin
    partial_data = '0;
    partial_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      if (CW'(i) < asm_cnt) begin
        partial_data[i*DATA_WIDTH +: DATA_WIDTH] = asm_data[i*DATA_WIDTH +: DATA_WIDTH];
        partial_keep[i] = 1'b1;
      end
    end
  end

  // Flush sequencing: stop reads, let in-flight data land and full words leave, then emit what is left
  always_comb begin
    state_next = state;
    case (state)
      FILL: begin
        if (flush) state_next = DRAIN;
      end
      DRAIN: begin
        if (!pend && (asm_cnt != FULL)) begin
          state_next = (asm_cnt == '0) ? FILL : EMIT;
        end
      end
      EMIT: begin
        if (slot_free) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FILL;
    else      state <= state_next;
  end

  // Assembly register: land the read issued last cycle into the next free lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_data <= '0;
      asm_cnt  <= '0;
      pend     <= 1'b0;
    end else begin
      pend <= fifo_rd_en;
      if (xfer || emit_fire) begin
        asm_cnt <= '0;
      end else if (pend) begin
        for (int i = 0; i < LANES; i++) begin
          if (asm_cnt == CW'(i)) asm_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_data;
        end
        asm_cnt <= asm_cnt + CW'(1);
      end
    end
  end

  // Output slot: load a full or flushed word when free, otherwise hold until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= asm_data;
      out_keep  <= '1;
      out_last  <= 1'b0;
    end else if (emit_fire) begin
      out_valid <= 1'b1;
      out_data  <= partial_data;
      out_keep  <= partial_keep;
      out_last  <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - self-checking bench for fifo_word_packer with a sync_fifo model
module tb_fifo_word_packer;

  localparam int DW = 8;
  localparam int LN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW*LN-1:0] out_data;
  logic [LN-1:0] out_keep;
  logic          out_last;

  fifo_word_packer #(.DATA_WIDTH(DW), .LANES(LN)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*LN-1:0] data;
    logic [LN-1:0]    keep;
    logic             last;
  } beat_t;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rd_count = 0;
  int beat_cnt = 0;

  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] mem[$];
  logic [DW-1:0] pend_bytes[$];
  beat_t         exp_q[$];
  int            beat_cyc[$];
  logic [DW*LN-1:0] got_data[$];
  logic [LN-1:0] got_keep[$];
  logic          got_last[$];

  logic          prev_hold = 1'b0;
  logic [DW*LN-1:0] prev_data;
  logic [LN-1:0] prev_keep;
  logic          prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // sync_fifo model: one write per cycle from wr_q, registered read data
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        rd_count++;
        if (mem.size() > 0) fifo_rd_data <= mem.pop_front();
      end
      if (wr_q.size() > 0) mem.push_back(wr_q.pop_front());
      fifo_empty <= (mem.size() == 0);
    end
  end

  // Compare process: protocol checks and beat scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      check("rd_en_while_empty", {63'd0, fifo_rd_en && fifo_empty}, 64'd0);
      if (prev_hold) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_data", {32'd0, out_data}, {32'd0, prev_data});
        check("hold_keep_last", {59'd0, out_keep, out_last}, {59'd0, prev_keep, prev_last});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", {32'd0, out_data}, {32'd0, e.data});
          check("beat_keep", {60'd0, out_keep}, {60'd0, e.keep});
          check("beat_last", {63'd0, out_last}, {63'd0, e.last});
        end
        beat_cyc.push_back(cyc);
        got_data.push_back(out_data);
        got_keep.push_back(out_keep);
        got_last.push_back(out_last);
        beat_cnt++;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_keep = out_keep;
      prev_last = out_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: every LN written bytes form one full beat, first byte in the low lane
  task automatic push_byte(input logic [DW-1:0] b);
    beat_t e;
    wr_q.push_back(b);
    pend_bytes.push_back(b);
    if (pend_bytes.size() == LN) begin
      e.data = '0;
      for (int i = 0; i < LN; i++) e.data[i*DW +: DW] = pend_bytes[i];
      e.keep = '1;
      e.last = 1'b0;
      exp_q.push_back(e);
      pend_bytes.delete();
    end
  endtask

  // Model: a flush turns any leftover bytes into one masked, last-marked beat
  task automatic do_flush();
    beat_t e;
    if (pend_bytes.size() > 0) begin
      e.data = '0;
      e.keep = '0;
      for (int i = 0; i < pend_bytes.size(); i++) begin
        e.data[i*DW +: DW] = pend_bytes[i];
        e.keep[i] = 1'b1;
      end
      e.last = 1'b1;
      exp_q.push_back(e);
      pend_bytes.delete();
    end
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int t = 0;
    while (beat_cnt < n && t < budget) begin
      tick(1);
      t++;
    end
    check(name, beat_cnt, n);
  endtask

  task automatic wait_reads(input int n, input int budget, input string name);
    int t = 0;
    while (rd_count < n && t < budget) begin
      tick(1);
      t++;
    end
    check(name, rd_count, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int rbase;
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    tick(3);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", {32'd0, out_data}, 64'd0);
    check("reset_keep_last", {59'd0, out_keep, out_last}, 64'd0);
    check("reset_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    rst = 1'b1;
    tick(2);

    // Two full words
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    wait_beats(2, 80, "t1_beats");
    check("t1_word0", {32'd0, got_data[0]}, 64'h04030201);
    check("t1_word1", {32'd0, got_data[1]}, 64'h08070605);
    check("t1_keep_last", {59'd0, got_keep[1], got_last[1]}, {59'd0, 4'hF, 1'b0});

    // Partial word by flush, then normal packing resumes
    rbase = rd_count;
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    wait_reads(rbase + 3, 40, "t2_reads");
    tick(3);
    do_flush();
    wait_beats(3, 40, "t2_flush_beat");
    check("t2_partial_data", {32'd0, got_data[2]}, 64'h00A3A2A1);
    check("t2_partial_keep_last", {59'd0, got_keep[2], got_last[2]}, {59'd0, 4'h7, 1'b1});
    for (int i = 0; i < 4; i++) push_byte(8'hB1 + 8'(i));
    wait_beats(4, 40, "t2_resume_beat");
    check("t2_resume_data", {32'd0, got_data[3]}, 64'hB4B3B2B1);

    // Flush with nothing assembled produces no beat
    n = beat_cnt;
    do_flush();
    for (int i = 0; i < 6; i++) begin
      check("t3_no_valid", {63'd0, out_valid}, 64'd0);
      tick(1);
    end
    check("t3_no_beat", beat_cnt, n);

    // Backpressure: one word held, one word assembled, then reads stop
    out_ready = 1'b0;
    n = beat_cnt;
    rbase = rd_count;
    for (int i = 0; i < 12; i++) push_byte(8'h10 + 8'(i));
    tick(40);
    check("t4_reads_capped", rd_count - rbase, 8);
    check("t4_held_valid", {63'd0, out_valid}, 64'd1);
    check("t4_held_word", {32'd0, out_data}, 64'h13121110);
    do_flush();
    tick(3);
    check("t4_reads_after_flush", rd_count - rbase, 8);
    out_ready = 1'b1;
    wait_beats(n + 3, 60, "t4_beats");
    check("t4_word1", {32'd0, got_data[n+1]}, 64'h17161514);
    check("t4_word2", {32'd0, got_data[n+2]}, 64'h1B1A1918);
    check("t4_last_clear", {63'd0, got_last[n+2]}, 64'd0);
    tick(6);
    check("t4_no_extra_beat", beat_cnt, n + 3);

    // Sustained throughput: one beat every LN+1 cycles
    n = beat_cnt;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    wait_beats(n + 4, 100, "t5_beats");
    for (int i = 1; i < 4; i++) check("t5_beat_spacing", beat_cyc[n+i] - beat_cyc[n+i-1], LN + 1);

    // Reset mid-word with two lanes landed and one read in flight
    rbase = rd_count;
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    wait_reads(rbase + 3, 40, "t6_reads");
    rst = 1'b0;
    pend_bytes.delete();
    #1;
    check("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t6_rst_data", {32'd0, out_data}, 64'd0);
    check("t6_rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    tick(1);
    rst = 1'b1;
    tick(2);
    n = beat_cnt;
    for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i));
    wait_beats(n + 1, 40, "t6_post_reset_beat");
    check("t6_post_reset_word", {32'd0, got_data[n]}, 64'h44434241);
    tick(6);
    check("t6_single_beat", beat_cnt, n + 1);

    check("exp_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of sync_fifo: drains its byte-wide read port and packs LANES consecutive entries into one wide word.
- Output is a registered valid/ready stream.
- A flush request emits any partially filled word with a byte-keep mask and a last marker.
- Sits between sync_fifo and the wide-datapath consumer.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry.
- LANES, 4, entries packed per output word; must be ≥2.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  empty flag from sync_fifo.
- fifo_rd_en  output  1  read strobe to sync_fifo.
- fifo_rd_data  input  DATA_WIDTH  sync_fifo read data; valid the cycle after fifo_rd_en is sampled high.
- flush  input  1  single-cycle request to emit the partial word.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_WIDTH*LANES  packed word; first-read entry in bits [DATA_WIDTH-1:0].
- out_keep  output  LANES  bit i set = lane i holds real data.
- out_last  output  1  marks a flush-terminated word.

Behaviour:
- Reset (rst low, asynchronous):
  - fifo_rd_en, out_valid, out_keep and out_last = 0; out_data = 0.
  - Assembly count, pending flag and flush request cleared; state = FILL.
  - An in-flight read is discarded; its data is never captured.
- Internal state:
  - asm_data / asm_cnt (0..LANES): lanes landed in the assembly register.
  - pend: one read issued last cycle, data arriving this cycle.
- Landing: when pend=1, fifo_rd_data is written to lane asm_cnt and asm_cnt increments.
- Transfer:
  - Fires when asm_cnt==LANES and the output slot is free (out_valid==0 or out_ready==1).
  - Effect: out_data<=asm_data, out_keep<=all ones, out_last<=0, out_valid<=1, asm_cnt<=0.
- Output handshake:
  - out_valid holds until out_valid && out_ready.
  - out_data, out_keep and out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid drops after acceptance unless a new transfer fires the same cycle (back-to-back beats allowed).
- Read issue: fifo_rd_en = state==FILL && !fifo_empty && (post-transfer asm_cnt + pend) < LANES.
  - Purely combinational from registered state and fifo_empty.
  - Never asserted while fifo_empty=1, so the FIFO never underflows.
  - Issuing in the same cycle a full word transfers is permitted.
  - Sustained throughput: LANES entries per LANES+1 cycles.
- States:
  - FILL: normal packing. flush=1 latches the request and goes to DRAIN; rd_en is suppressed from that cycle.
  - DRAIN: waits until pend==0, and for any full-word transfer to complete.
    - asm_cnt==0: go to FILL, nothing emitted.
    - Otherwise go to EMIT.
  - EMIT: when the output slot is free, load out_data with asm_data, unused lanes zero.
    - out_keep = (1<<asm_cnt)-1, out_last=1, out_valid=1, asm_cnt<=0, then go to FILL.
- flush pulses in DRAIN or EMIT are ignored.
- flush arriving with asm_cnt==LANES and no pending read: the full word transfers normally with out_last=0, and no extra beat is produced.
- Backpressure: with out_ready=0 and the output slot occupied, at most LANES further entries are read (assembly fills), then reads stop. No data is lost or reordered.
- fifo_empty toggling mid-word only stalls packing; the word is never emitted partial without flush.

Test Plan:
- Write 8 entries 0x01..0x08 to FIFO, out_ready=1 -> two beats: out_data=0x04030201 then 0x08070605, out_keep=4'hF, out_last=0. fifo_rd_en is never high while fifo_empty=1.
- Write 3 entries 0xA1,0xA2,0xA3, wait for all to be read, pulse flush -> one beat: out_data=0x00A3A2A1, out_keep=4'h7, out_last=1. Then FILL resumes and a following 4 entries pack normally.
- Pulse flush with FIFO empty and asm_cnt=0 -> no beat; out_valid stays 0; state returns to FILL within 2 cycles.
- Write 12 entries with out_ready held 0 -> first word held stable on out_data, and exactly 4 more reads occur. After out_ready=1, 3 beats arrive in order with no duplication.
- Write 16 entries with out_ready=1 continuously -> 4 beats; each beat follows the previous by exactly 5 cycles after the pipeline fills.
- Drive rst low for 1 cycle mid-word (2 lanes landed, 1 read pending) -> outputs 0 immediately. A subsequent 4-entry write yields a word containing only post-reset data.
